lane_scheduler_rr4: RTL and testbench
=====================================

# lane_scheduler_rr4

Round-robin scheduler that drains four first-word-fall-through lane FIFOs into a single 8-bit word stream for the L1 mux path. It arbitrates among non-empty lanes, pops the winner and forwards one registered word per cycle. It honours downstream backpressure and reports idle status to the bench and the link controller. A small RESET/INIT/IDLE/ACTIVE state machine gates all activity.

## Interface
Parameters:
- DATA_W, 8, word width of every lane and of the output
- IDLE_CYCLES, 4, consecutive all-empty ACTIVE cycles before returning to IDLE (range 1..15)

Ports:
- clk_f  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- init  in  1  level; forces/holds INIT state
- data_in_0..data_in_3  in  DATA_W  head word of lane FIFO n, valid while empty_n=0
- empty_0..empty_3  in  1  lane FIFO n empty flag
- out_almost_full  in  1  downstream cannot accept a word this cycle
- pop_0..pop_3  out  1  combinational pop to lane FIFO n, at most one high per cycle
- data_out  out  DATA_W  registered forwarded word
- valid_out  out  1  data_out qualifier
- lane_out  out  2  source lane of data_out
- idle_out  out  1  high in IDLE state only
- state_out  out  2  current state code

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3; state_out is the state register itself.
- RESET is entered from any state while reset=1. From RESET with reset=0: go to INIT.
- INIT: stay while init=1. Leave to IDLE when init=0.
- IDLE: idle_out=1 and no pops. Go to ACTIVE when any empty_n=0 and out_almost_full=0.
- ACTIVE, per cycle:
  - Eligible when out_almost_full=0 and at least one lane is non-empty.
  - Grant = first non-empty lane searching ptr, ptr+1, ... modulo 4.
  - pop_grant=1 in the same cycle as the grant.
  - Next edge: data_out<=data_in_grant, valid_out<=1, lane_out<=grant, ptr<=grant+1 (2-bit wrap, 3->0).
  - Not eligible: no pop, valid_out<=0, and data_out/lane_out hold their values.
- Idle counter (4-bit):
  - Increments on each ACTIVE cycle with all lanes empty and clears otherwise.
  - Reaching IDLE_CYCLES moves the state to IDLE and clears the counter.
  - Cycles blocked by almost_full with lanes non-empty do not count.
- init=1 in IDLE or ACTIVE: go to INIT next edge, pops suppressed that cycle, valid_out<=0, and ptr retained.
- Pops are 0 in RESET, INIT and IDLE.

## Timing
- Reset values:
  - state=RESET, ptr=0, idle counter=0
  - data_out=0, valid_out=0, lane_out=0
  - idle_out=0, all pop_n=0, since the pops are gated by state
- Pop-to-output latency: 1 cycle.
- Empty deasserts while IDLE: the next cycle is ACTIVE with the first pop, and valid_out follows 2 cycles after the empty change.
- out_almost_full is sampled combinationally. If it rises in cycle N, there is no pop in N and valid_out=0 at N+1.
- Lane empty in the same cycle that ptr points to it: the lane is skipped, with no stall cycle.
- Reset has priority over init. Reset mid-ACTIVE drops pops in that same cycle, and all outputs are at reset values after the edge.
- Throughput is one word per cycle when unblocked. No lane is starved: worst-case wait is 3 grants.

## Structure
- Shared package `sched_pkg` holds:
  - state codes RESET/INIT/IDLE/ACTIVE (2-bit)
  - NLANES=4
  - lane index width 2
  - default DATA_W and IDLE_CYCLES
- One sub-module, `rr_priority4`: inputs req[3:0] and ptr[1:0]; outputs gnt_valid and gnt_idx[1:0]. Purely combinational rotated priority encoder, instantiated once.
- Top holds the FSM, ptr, idle counter, output registers and pop decode.

## Test plan
- Reset held 3 cycles, then reset=0 with init=1 for 2 cycles, then init=0 -> state_out 0,1,1,2; idle_out=1 only in IDLE; all pops 0 throughout.
- One word in each lane (ff,ee,dd,cc), ptr=0 -> data_out ff,ee,dd,cc on 4 consecutive cycles, lane_out 0,1,2,3. After 4 empty ACTIVE cycles, state returns to IDLE.
- Only lane 2 holds 77,78,79 -> three back-to-back pop_2 pulses; data_out 77,78,79 with lane_out=2; ptr ends at 3.
- Lanes 0 and 3 always non-empty, last grant 3 -> grant sequence 0,3,0,3. Lanes 1 and 2 are never popped.
- out_almost_full high for 2 cycles mid-stream -> no pops, valid_out=0 for 2 cycles, data_out held. Arbitration resumes at the pending ptr lane.
- reset=1 during ACTIVE with all lanes non-empty -> no pop that cycle; after the edge, data_out=0, valid_out=0 and state_out=0.

Source files
------------

// File: rtl/sched_pkg.sv
// Shared definitions for the four-lane round-robin scheduler: state codes,
// lane geometry and default parameter values.
package sched_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  localparam int NLANES          = 4;
  localparam int LANE_W          = 2;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_IDLE_CYCLES = 4;

endpackage

// File: rtl/lane_scheduler_rr4_if.sv
// Bundle of lane FIFO heads/flags, downstream backpressure and the forwarded
// word stream between the scheduler (master) and its environment (slave).
interface lane_scheduler_rr4_if
  import sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              init;
  logic [DATA_W-1:0] data_in_0;
  logic [DATA_W-1:0] data_in_1;
  logic [DATA_W-1:0] data_in_2;
  logic [DATA_W-1:0] data_in_3;
  logic              empty_0;
  logic              empty_1;
  logic              empty_2;
  logic              empty_3;
  logic              out_almost_full;
  logic              pop_0;
  logic              pop_1;
  logic              pop_2;
  logic              pop_3;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [LANE_W-1:0] lane_out;
  logic              idle_out;
  logic [1:0]        state_out;

  modport master (
    input  init, data_in_0, data_in_1, data_in_2, data_in_3,
           empty_0, empty_1, empty_2, empty_3, out_almost_full,
    output pop_0, pop_1, pop_2, pop_3,
           data_out, valid_out, lane_out, idle_out, state_out
  );

  modport slave (
    output init, data_in_0, data_in_1, data_in_2, data_in_3,
           empty_0, empty_1, empty_2, empty_3, out_almost_full,
    input  pop_0, pop_1, pop_2, pop_3,
           data_out, valid_out, lane_out, idle_out, state_out
  );
endinterface

// File: rtl/rr_priority4.sv
// Rotated priority encoder: picks the first requesting lane starting at ptr
// and wrapping modulo four. Purely combinational.
module rr_priority4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx
);

  always_comb begin
    logic       found;
    logic [1:0] idx;
    gnt_valid = |req;
    gnt_idx   = ptr;
    found     = 1'b0;
    idx       = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_scheduler_rr4.sv
// Four-lane round-robin scheduler: pops the granted lane FIFO and forwards its
// head word through one output register, under a RESET/INIT/IDLE/ACTIVE FSM.
module lane_scheduler_rr4
  import sched_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input logic                  clk_f,
  input logic                  reset,
  lane_scheduler_rr4_if.master bus
);

  state_e            state_q, state_d;
  logic [LANE_W-1:0] ptr_q, ptr_d;
  logic [3:0]        idle_cnt_q, idle_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [LANE_W-1:0] lane_q, lane_d;

  logic [NLANES-1:0] req;
  logic              gnt_valid;
  logic [LANE_W-1:0] gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic              fire;
  logic [3:0]        idle_cnt_inc;

  assign req = ~{bus.empty_3, bus.empty_2, bus.empty_1, bus.empty_0};

  rr_priority4 u_arb (
    .req       (req),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    gnt_data = bus.data_in_0;
    case (gnt_idx)
      2'd1:    gnt_data = bus.data_in_1;
      2'd2:    gnt_data = bus.data_in_2;
      2'd3:    gnt_data = bus.data_in_3;
      default: gnt_data = bus.data_in_0;
    endcase
  end

  // Reset in the same cycle must already suppress the pop, not just the state.
  assign fire = (state_q == ST_ACTIVE) && !bus.init && !bus.out_almost_full
                && gnt_valid && !reset;

  assign bus.pop_0 = fire && (gnt_idx == 2'd0);
  assign bus.pop_1 = fire && (gnt_idx == 2'd1);
  assign bus.pop_2 = fire && (gnt_idx == 2'd2);
  assign bus.pop_3 = fire && (gnt_idx == 2'd3);

  assign idle_cnt_inc = idle_cnt_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idle_cnt_d = 4'd0;
    data_d     = data_q;
    valid_d    = 1'b0;
    lane_d     = lane_q;

    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!bus.init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.init)                                state_d = ST_INIT;
        else if (gnt_valid && !bus.out_almost_full) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init) begin
          state_d = ST_INIT;
        end else if (!gnt_valid) begin
          // Only fully empty cycles count; backpressured cycles with work pending clear it.
          idle_cnt_d = idle_cnt_inc;
          if (idle_cnt_inc == 4'(IDLE_CYCLES)) begin
            state_d    = ST_IDLE;
            idle_cnt_d = 4'd0;
          end
        end
      end
      default: state_d = ST_RESET;
    endcase

    if (fire) begin
      data_d  = gnt_data;
      valid_d = 1'b1;
      lane_d  = gnt_idx;
      ptr_d   = gnt_idx + 2'd1;
    end
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state_q    <= ST_RESET;
      ptr_q      <= '0;
      idle_cnt_q <= 4'd0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idle_cnt_q <= idle_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      lane_q     <= lane_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.lane_out  = lane_q;
  assign bus.idle_out  = (state_q == ST_IDLE);
  assign bus.state_out = state_q;

endmodule

// File: tb/tb_lane_scheduler_rr4.sv
// Scoreboard bench for lane_scheduler_rr4: lane FIFOs and a behavioural model
// predict pops, state and forwarded words; a monitor checks the output stream.
module tb_lane_scheduler_rr4;
  import sched_pkg::*;

  localparam int DW = 8;
  localparam int IC = 4;

  logic clk_f = 1'b0;
  logic reset = 1'b1;
  always #5 clk_f = ~clk_f;

  lane_scheduler_rr4_if #(.DATA_W(DW)) sif ();

  lane_scheduler_rr4 #(.DATA_W(DW), .IDLE_CYCLES(IC)) dut (
    .clk_f (clk_f),
    .reset (reset),
    .bus   (sif)
  );

  typedef struct {
    logic [7:0] d;
    int         lane;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo[4][256];
  int         head[4];
  int         tail[4];

  int         m_mode;
  int         m_ptr;
  int         m_cnt;
  logic [7:0] m_data;
  int         m_lane;
  bit         m_valid;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] head_word(input int l);
    return (tail[l] != head[l]) ? fifo[l][head[l] % 256] : 8'h00;
  endfunction

  task automatic push(input int l, input logic [7:0] d);
    fifo[l][tail[l] % 256] = d;
    tail[l]++;
  endtask

  task automatic drive_lanes();
    sif.empty_0   = (tail[0] == head[0]);
    sif.empty_1   = (tail[1] == head[1]);
    sif.empty_2   = (tail[2] == head[2]);
    sif.empty_3   = (tail[3] == head[3]);
    sif.data_in_0 = head_word(0);
    sif.data_in_1 = head_word(1);
    sif.data_in_2 = head_word(2);
    sif.data_in_3 = head_word(3);
  endtask

  // One clock: drive, predict and check combinational outputs, then advance lanes and model.
  task automatic cycle(input bit r, input bit i, input bit a);
    int         g;
    bit         any;
    bit         fire;
    logic [3:0] p;
    logic [3:0] ep;
    logic [7:0] w;
    @(negedge clk_f);
    reset               = r;
    sif.init            = i;
    sif.out_almost_full = a;
    drive_lanes();
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      int ln;
      ln = (m_ptr + k) % 4;
      if (g < 0 && tail[ln] != head[ln]) g = ln;
    end
    any  = (g >= 0);
    fire = (m_mode == 3) && !r && !i && !a && any;
    w    = fire ? head_word(g) : 8'h00;
    ep   = fire ? 4'(1 << g) : 4'b0000;
    p    = {sif.pop_3, sif.pop_2, sif.pop_1, sif.pop_0};
    chk("pop", 32'(p), 32'(ep));
    chk("state_out", 32'(sif.state_out), 32'(m_mode));
    chk("idle_out", 32'(sif.idle_out), 32'(m_mode == 2));
    if (fire) exp_q.push_back('{w, g});
    @(posedge clk_f);
    for (int k = 0; k < 4; k++)
      if (p[k] === 1'b1 && tail[k] != head[k]) head[k]++;
    if (r) begin
      m_mode = 0; m_ptr = 0; m_cnt = 0;
      m_data = 8'h00; m_lane = 0; m_valid = 1'b0;
    end else begin
      m_valid = fire;
      if (fire) begin
        m_data = w;
        m_lane = g;
        m_ptr  = (g + 1) % 4;
      end
      case (m_mode)
        0: m_mode = 1;
        1: if (!i) m_mode = 2;
        2: begin
          if (i) m_mode = 1;
          else if (any && !a) m_mode = 3;
        end
        default: begin
          if (i) begin
            m_mode = 1;
            m_cnt  = 0;
          end else if (!any) begin
            m_cnt++;
            if (m_cnt == IC) begin
              m_mode = 2;
              m_cnt  = 0;
            end
          end else begin
            m_cnt = 0;
          end
        end
      endcase
    end
  endtask

  // Monitor: every registered output cycle is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_f);
      chk("valid_out", 32'(sif.valid_out), 32'(m_valid));
      if (sif.valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h lane=%0d required=none at %0t",
                   sif.data_out, sif.lane_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", 32'(sif.data_out), 32'(e.d));
          chk("lane_out", 32'(sif.lane_out), 32'(e.lane));
        end
      end else begin
        chk("hold_data", 32'(sif.data_out), 32'(m_data));
        chk("hold_lane", 32'(sif.lane_out), 32'(m_lane));
      end
    end
  end

  initial begin
    int n;
    m_mode = 0; m_ptr = 0; m_cnt = 0;
    m_data = 8'h00; m_lane = 0; m_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    sif.init            = 1'b0;
    sif.out_almost_full = 1'b0;
    drive_lanes();

    // Reset, init hold, release to IDLE
    repeat (3) cycle(1, 0, 0);
    repeat (2) cycle(0, 1, 0);
    repeat (3) cycle(0, 0, 0);

    // One word per lane, then idle timeout back to IDLE
    push(0, 8'hff); push(1, 8'hee); push(2, 8'hdd); push(3, 8'hcc);
    repeat (12) cycle(0, 0, 0);

    // Only lane 2 populated
    push(2, 8'h77); push(2, 8'h78); push(2, 8'h79);
    repeat (10) cycle(0, 0, 0);

    // Lanes 0 and 3 busy, alternate grants
    for (int k = 0; k < 4; k++) begin
      push(0, 8'h10 + 8'(k));
      push(3, 8'h30 + 8'(k));
    end
    repeat (12) cycle(0, 0, 0);

    // Backpressure mid-stream
    for (int k = 0; k < 4; k++) begin
      push(k, 8'h40 + 8'(k));
      push(k, 8'h50 + 8'(k));
    end
    repeat (3) cycle(0, 0, 0);
    repeat (2) cycle(0, 0, 1);
    repeat (10) cycle(0, 0, 0);

    // Reset while ACTIVE with all lanes non-empty
    for (int k = 0; k < 4; k++) begin
      push(k, 8'h60 + 8'(k));
      push(k, 8'h70 + 8'(k));
    end
    repeat (2) cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (3) cycle(0, 0, 0);
    cycle(0, 1, 0);
    repeat (12) cycle(0, 0, 0);

    // Randomized traffic with occasional backpressure, init and reset
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 4; k++)
        if ((tail[k] - head[k]) < 12 && $urandom_range(99) < 30)
          push(k, 8'($urandom_range(255)));
      cycle($urandom_range(199) < 1, $urandom_range(99) < 2, $urandom_range(99) < 20);
    end

    // Drain remaining words, bounded
    n = 0;
    while (n < 300 && (tail[0] != head[0] || tail[1] != head[1] ||
                       tail[2] != head[2] || tail[3] != head[3])) begin
      cycle(0, 0, 0);
      n++;
    end
    repeat (3) cycle(0, 0, 0);
    chk("lanes_drained", 32'((tail[0] - head[0]) + (tail[1] - head[1]) +
                             (tail[2] - head[2]) + (tail[3] - head[3])), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
